// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding,
// opcode constants, ALU/MU operation codes and the decoded-instruction record.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_MULWAIT = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd5
    } state_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [1:0] MU_MUL    = 2'b00;
    localparam logic [1:0] MU_MULH   = 2'b01;
    localparam logic [1:0] MU_MULHSU = 2'b10;
    localparam logic [1:0] MU_MULHU  = 2'b11;

    typedef struct packed {
        logic       legal;
        logic       is_mul;
        logic       is_imm;
        logic [3:0] aluop;
        logic [1:0] mulop;
    } dec_t;

    // ALU operation selected by func3 when func7 carries no modifier.
    function automatic logic [3:0] alu_base(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: instruction fields and EX-stage status in,
// datapath control strobes and selects out.
interface control_unit_if #(
    parameter int PCMUX_N     = 2,
    parameter int IFURESCTL_N = 2
);
    localparam int PCW = (PCMUX_N > 1) ? $clog2(PCMUX_N) : 1;
    localparam int IFW = (IFURESCTL_N > 1) ? $clog2(IFURESCTL_N) : 1;

    logic [6:0]     opcode;
    logic [2:0]     func3;
    logic [1:0]     func7b50;
    // MU handshake: mulstart is a one-cycle request; the MU answers with
    // exdone, which the control unit only looks at while waiting in MULWAIT.
    logic           exdone;

    logic [PCW-1:0] pcmuxctl;
    logic           pcnextctl;
    logic           instrre;
    logic           regre;
    logic           regwe;
    logic           bmuxctl;
    logic [3:0]     aluctl;
    logic           mulstart;
    logic [1:0]     mulctl;
    logic [IFW-1:0] ifuresctl;
    logic           trap;

    modport master (
        output opcode, func3, func7b50, exdone,
        input  pcmuxctl, pcnextctl, instrre, regre, regwe, bmuxctl,
               aluctl, mulstart, mulctl, ifuresctl, trap
    );

    modport slave (
        input  opcode, func3, func7b50, exdone,
        output pcmuxctl, pcnextctl, instrre, regre, regwe, bmuxctl,
               aluctl, mulstart, mulctl, ifuresctl, trap
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/func3/func7 bits to legality,
// unit selection and operation codes.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_func3,
    input  logic [1:0] i_func7b50,
    output dec_t       o_dec
);

    always_comb begin
        o_dec = '0;
        case (i_opcode)
            OP_R: begin
                case (i_func7b50)
                    2'b00: begin
                        o_dec.legal = 1'b1;
                        o_dec.aluop = alu_base(i_func3);
                    end
                    2'b10: begin
                        if (i_func3 == 3'b000) begin
                            o_dec.legal = 1'b1;
                            o_dec.aluop = ALU_SUB;
                        end else if (i_func3 == 3'b101) begin
                            o_dec.legal = 1'b1;
                            o_dec.aluop = ALU_SRA;
                        end
                    end
                    2'b01: begin
                        // Divide/remainder (func3[2]=1) have no unit here.
                        if (!i_func3[2]) begin
                            o_dec.legal  = 1'b1;
                            o_dec.is_mul = 1'b1;
                            o_dec.mulop  = i_func3[1:0];
                        end
                    end
                    default: ;
                endcase
            end
            OP_I: begin
                o_dec.is_imm = 1'b1;
                case (i_func3)
                    3'b001: begin
                        o_dec.legal = !i_func7b50[1];
                        o_dec.aluop = ALU_SLL;
                    end
                    3'b101: begin
                        o_dec.legal = 1'b1;
                        o_dec.aluop = i_func7b50[1] ? ALU_SRA : ALU_SRL;
                    end
                    default: begin
                        o_dec.legal = 1'b1;
                        o_dec.aluop = alu_base(i_func3);
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/(MULWAIT)/WB sequencer for a single-issue core,
// with a sticky trap state for illegal instructions and MU timeouts.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int PCMUX_N     = 2,
    parameter int IFURESCTL_N = 2,
    parameter int MUL_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.slave  bus,
    output state_t         o_dbg_state
);

    localparam int CW = $clog2(MUL_TIMEOUT + 1);

    state_t        r_state;
    state_t        w_next;
    dec_t          w_dec;
    logic          r_is_mul;
    logic          r_is_imm;
    logic [3:0]    r_aluop;
    logic [1:0]    r_mulop;
    logic [CW-1:0] r_cnt;
    logic          w_ifu_mu;

    ctrl_decode u_decode (
        .i_opcode   (bus.opcode),
        .i_func3    (bus.func3),
        .i_func7b50 (bus.func7b50),
        .o_dec      (w_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_FETCH;
            r_is_mul <= 1'b0;
            r_is_imm <= 1'b0;
            r_aluop  <= '0;
            r_mulop  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_is_mul <= w_dec.is_mul;
                r_is_imm <= w_dec.is_imm;
                r_aluop  <= w_dec.aluop;
                r_mulop  <= w_dec.mulop;
            end
            // Counts MULWAIT cycles; cleared everywhere else.
            if (r_state == ST_MULWAIT) r_cnt <= r_cnt + 1'b1;
            else                       r_cnt <= '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:   w_next = ST_DECODE;
            ST_DECODE:  w_next = w_dec.legal ? ST_EXEC : ST_TRAP;
            ST_EXEC:    w_next = r_is_mul ? ST_MULWAIT : ST_WB;
            ST_MULWAIT: begin
                if (bus.exdone)                          w_next = ST_WB;
                else if (r_cnt == CW'(MUL_TIMEOUT - 1))  w_next = ST_TRAP;
            end
            ST_WB:      w_next = ST_FETCH;
            ST_TRAP:    w_next = ST_TRAP;
            default:    w_next = ST_FETCH;
        endcase
    end

    // Outputs are forced low while rst_n is held so the reset cycle itself is quiet.
    always_comb begin
        bus.pcmuxctl  = '0;
        bus.pcnextctl = 1'b0;
        bus.instrre   = 1'b0;
        bus.regre     = 1'b0;
        bus.regwe     = 1'b0;
        bus.bmuxctl   = 1'b0;
        bus.aluctl    = '0;
        bus.mulstart  = 1'b0;
        bus.mulctl    = '0;
        bus.trap      = 1'b0;
        w_ifu_mu      = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_FETCH:  bus.instrre = 1'b1;
                ST_DECODE: bus.regre   = 1'b1;
                ST_EXEC, ST_WB: begin
                    if (r_is_mul) begin
                        bus.mulctl = r_mulop;
                        w_ifu_mu   = 1'b1;
                    end else begin
                        bus.aluctl  = r_aluop;
                        bus.bmuxctl = r_is_imm;
                    end
                    bus.mulstart  = (r_state == ST_EXEC) && r_is_mul;
                    bus.regwe     = (r_state == ST_WB);
                    bus.pcnextctl = (r_state == ST_WB);
                end
                ST_MULWAIT: begin
                    bus.mulctl = r_mulop;
                    w_ifu_mu   = 1'b1;
                end
                ST_TRAP:   bus.trap = 1'b1;
                default: ;
            endcase
        end
        bus.ifuresctl    = '0;
        bus.ifuresctl[0] = w_ifu_mu;
    end

    assign o_dbg_state = r_state;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter PCMUX_N, default 2, number of pcmuxctl sources.
REQ-002 Parameter IFURESCTL_N, default 2, number of ifuresctl sources (0 ALU, 1 MU).
REQ-003 Parameter MUL_TIMEOUT, default 64, max cycles waiting for exdone before trap.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 opcode  in  7  instr[6:0] from datapath.
REQ-007 func3  in  3  instr[14:12].
REQ-008 func7b50  in  2  {instr[30],instr[25]}.
REQ-009 exdone  in  1  EX-stage valid from datapath.
REQ-010 pcmuxctl  out  $clog2(PCMUX_N)  PC source select; always 0 (pc+4).
REQ-011 pcnextctl  out  1  PC update enable.
REQ-012 instrre  out  1  instruction read enable.
REQ-013 regre  out  1  regfile read enable.
REQ-014 regwe  out  1  regfile write enable.
REQ-015 bmuxctl  out  1  0 register B, 1 immediate.
REQ-016 aluctl  out  4  ALU operation.
REQ-017 mulstart  out  1  MU start pulse.
REQ-018 mulctl  out  2  MU operation.
REQ-019 ifuresctl  out  $clog2(IFURESCTL_N)  result select.
REQ-020 trap  out  1  sticky illegal-instruction/timeout flag.

Function
REQ-021 States: FETCH, DECODE, EXEC, MULWAIT, WB, TRAP; one-hot or binary is free.
REQ-022 FETCH: instrre=1 for one cycle; next DECODE.
REQ-023 DECODE: regre=1; decode opcode/func3/func7b50 into registered fields (is_mul, is_imm, aluop, mulop); illegal -> TRAP, else EXEC.
REQ-024 Legal: opcode 0110011 with func7b50 00 (all func3), 10 (func3 000 SUB, 101 SRA), 01 with func3[2]=0 (MUL/MULH/MULHSU/MULHU); opcode 0010011 with any func3, except func3 001 requires func7b50[1]=0 and func3 101 maps func7b50[1] to SRLI/SRAI; ADDI ignores func7 bits; everything else illegal (including DIV/REM, func3[2]=1 with func7b50 01).
REQ-025 aluctl map: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
REQ-026 EXEC, ALU op: drive aluctl, bmuxctl=is_imm, ifuresctl=0; next WB.
REQ-027 EXEC, MUL op: mulstart=1 for exactly this one cycle, mulctl=func3[1:0], ifuresctl=1, bmuxctl=0; next MULWAIT.
REQ-028 MULWAIT: hold mulctl, ifuresctl=1, mulstart=0; counter increments each cycle; exdone=1 -> WB; counter reaching MUL_TIMEOUT without exdone -> TRAP.
REQ-029 WB: regwe=1 and pcnextctl=1 for one cycle with aluctl/bmuxctl/ifuresctl/mulctl held from EXEC; next FETCH.
REQ-030 Latency: ALU instruction 4 cycles; MUL instruction 4 + k cycles, k = MULWAIT cycles until exdone seen.
REQ-031 exdone in any state other than MULWAIT is ignored.
REQ-032 TRAP: trap=1, all enables and mulstart 0, PC frozen; leaves only via reset.
REQ-033 Outputs not named for a state are 0 in that state.

Reset
REQ-034 rst_n=0 at a clock edge: state FETCH-pending (first cycle after release is FETCH), all outputs 0, trap 0, counter 0, decoded fields 0.
REQ-035 Reset mid-instruction (any state, including MULWAIT) aborts without regwe or pcnextctl.

Structure
REQ-036 Shared package ctrl_pkg holds state encoding, opcode constants (OP_R 0110011, OP_I 0010011), aluctl and mulctl codes.
REQ-037 One sub-module ctrl_decode: combinational opcode/func3/func7b50 -> {legal, is_mul, is_imm, aluop, mulop}.

Verification
REQ-038 ADD (op 0110011, f3 000, f7 00) after reset -> instrre cycle 1, regre cycle 2, aluctl 0000 cycle 3, regwe+pcnextctl cycle 4.
REQ-039 SRAI (op 0010011, f3 101, f7b50 10) -> aluctl 0111, bmuxctl 1 in EXEC/WB; SLLI with f7b50 10 -> trap=1, no regwe.
REQ-040 MULHU (f7b50 01, f3 011), exdone after 3 MULWAIT cycles -> mulstart single pulse, mulctl 11, ifuresctl 1, regwe at cycle 7.
REQ-041 MUL with exdone never asserted -> trap=1 after MUL_TIMEOUT=64 MULWAIT cycles, regwe never 1.
REQ-042 rst_n low during MULWAIT -> next cycle all outputs 0; after release instrre=1, no pcnextctl for aborted instruction.
REQ-043 DIV (f7b50 01, f3 100) and opcode 0000011 -> trap=1 after DECODE, sticky until reset.
